// File: rtl/svnet_pipe_arb_pkg.sv
// Shared types for the pipelined-datapath arbiter: FSM states, ID width helper, and the tag carried beside the datapath.
// No logic. The tag ID field is sized for the largest supported requester count (16).
package svnet_pipe_arb_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      HALT  = 2'd2
   } arb_state_t;

   function automatic int id_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int TAG_ID_W = id_width(16);

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/svnet_reg_pipe.sv
// Generic register delay line: i_dat appears on o_dat DEPTH cycles later.
// Latency DEPTH cycles; every stage resets to INIT.
// No backpressure: it shifts every cycle.
module svnet_reg_pipe #(
   parameter int               WIDTH = 1,
   parameter int               DEPTH = 1,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_dat,
   output logic [WIDTH-1:0] o_dat
);

   logic [WIDTH-1:0] r_stage [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_stage[i] <= INIT;
      end else begin
         r_stage[0] <= i_dat;
         for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
      end
   end

   assign o_dat = r_stage[DEPTH-1];

endmodule

// File: rtl/svnet_rr_pick.sv
// Rotating-priority picker: the first requester at or after i_ptr (mod N) wins.
// Purely combinational, zero latency.
// No backpressure: the caller masks i_req when granting is not allowed.
module svnet_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx
);

   logic [IW:0] w_sum;
   logic        w_found;

   always_comb begin
      o_gnt   = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (IW+1)'(k);
         if (w_sum >= (IW+1)'(N)) w_sum = w_sum - (IW+1)'(N);
         if (!w_found && i_req[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            o_idx   = w_sum[IW-1:0];
         end
      end
      o_gnt[o_idx] = w_found;
   end

endmodule

// File: rtl/svnet_pipe_arbiter.sv
// Round-robin sharing of one fixed-latency datapath; results are steered back by a tag pipeline.
// Handshake at T -> dp_valid at T+1 -> rsp_valid at T+LATENCY+2; drain handshake empties it.
// Requesters are held by req_ready; responses have no backpressure. SVNET_PIPE_ARB_LOCK_EN adds req_lock.
module svnet_pipe_arbiter
   import svnet_pipe_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int LATENCY = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
`ifdef SVNET_PIPE_ARB_LOCK_EN
   input  logic [NUM_REQ-1:0]              req_lock,
`endif
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0][WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            dp_valid,
   output logic [WIDTH-1:0]                dp_data,
   input  logic [WIDTH-1:0]                dp_result,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [WIDTH-1:0]                rsp_data,
   input  logic                            drain_req,
   output logic                            drain_ack,
   output logic                            busy
);

   localparam int             ID_W    = id_width(NUM_REQ);
   localparam int             CNT_W   = $clog2(LATENCY + 3);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LATENCY + 2);
   localparam int             TAG_W   = $bits(tag_t);

   arb_state_t           r_state, w_state_nxt;
   logic [ID_W-1:0]      r_ptr;
   logic                 w_grant_en;
   logic [NUM_REQ-1:0]   w_pick_gnt, w_gnt;
   logic [ID_W-1:0]      w_pick_idx, w_idx;
   logic                 w_hs;
   logic                 r_dp_vld;
   logic [WIDTH-1:0]     r_dp_dat;
   logic [ID_W-1:0]      r_dp_id;
   tag_t                 w_tag_in, w_tag_out;
   logic [NUM_REQ-1:0]   r_rsp_vld;
   logic [WIDTH-1:0]     r_rsp_dat;
   logic                 w_rsp_any;
   logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
   logic                 r_busy;

   assign w_grant_en = (r_state == RUN) && !drain_req;

   svnet_rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
      .i_req (req_valid & {NUM_REQ{w_grant_en}}),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx)
   );

`ifdef SVNET_PIPE_ARB_LOCK_EN
   logic            r_last_vld;
   logic [ID_W-1:0] r_last_id;
   logic            w_lock_hit;

   assign w_lock_hit = w_grant_en && r_last_vld && req_lock[r_last_id] && req_valid[r_last_id];

   always_comb begin
      w_gnt = w_pick_gnt;
      w_idx = w_pick_idx;
      if (w_lock_hit) begin
         w_gnt            = '0;
         w_gnt[r_last_id] = 1'b1;
         w_idx            = r_last_id;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_vld <= 1'b0;
         r_last_id  <= '0;
      end else if (w_hs) begin
         r_last_vld <= 1'b1;
         r_last_id  <= w_idx;
      end
   end
`else
   assign w_gnt = w_pick_gnt;
   assign w_idx = w_pick_idx;
`endif

   assign w_hs = |(req_valid & w_gnt);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (drain_req) w_state_nxt = DRAIN;
         DRAIN:   if (r_cnt == '0) w_state_nxt = drain_req ? HALT : RUN;
         HALT:    if (!drain_req) w_state_nxt = RUN;
         default: w_state_nxt = DRAIN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= DRAIN;
         r_ptr    <= '0;
         r_dp_vld <= 1'b0;
         r_dp_dat <= '0;
         r_dp_id  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_dp_vld <= w_hs;
         if (w_hs) begin
            r_ptr    <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
            r_dp_dat <= req_data[w_idx];
            r_dp_id  <= w_idx;
         end
      end
   end

   // Tag travels beside the operand so it lines up with dp_result.
   assign w_tag_in = '{valid: r_dp_vld, id: TAG_ID_W'(r_dp_id)};

   svnet_reg_pipe #(.WIDTH(TAG_W), .DEPTH(LATENCY), .INIT({TAG_W{1'b0}})) u_tag_pipe (
      .clk   (clk),
      .rst_n (rst_n),
      .i_dat (w_tag_in),
      .o_dat (w_tag_out)
   );

   assign w_rsp_any = |r_rsp_vld;

   always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_hs, w_rsp_any})
         2'b10:   w_cnt_nxt = r_cnt + 1'b1;
         2'b01:   w_cnt_nxt = r_cnt - 1'b1;
         default: w_cnt_nxt = r_cnt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_vld <= '0;
         r_rsp_dat <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
      end else begin
         for (int k = 0; k < NUM_REQ; k++)
            r_rsp_vld[k] <= w_tag_out.valid && (w_tag_out.id == TAG_ID_W'(k));
         if (w_tag_out.valid) r_rsp_dat <= dp_result;
         r_cnt  <= w_cnt_nxt;
         r_busy <= (w_cnt_nxt != '0);
      end
   end

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(w_hs && !w_rsp_any && r_cnt == CNT_MAX));
         assert (!(w_rsp_any && !w_hs && r_cnt == '0));
      end
   end

   assign req_ready = w_gnt;
   assign dp_valid  = r_dp_vld;
   assign dp_data   = r_dp_dat;
   assign rsp_valid = r_rsp_vld;
   assign rsp_data  = r_rsp_dat;
   assign drain_ack = (r_state == HALT) && drain_req;
   assign busy      = r_busy;

endmodule

// File: tb/tb_svnet_pipe_arbiter.sv
// Directed bench for svnet_pipe_arbiter; the datapath model returns operand+1 after LATENCY cycles.
// Inputs change 1ns after the rising edge, outputs are checked on the falling edge.
module tb_svnet_pipe_arbiter;

   localparam int N = 4;
   localparam int W = 16;
   localparam int L = 3;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      req_valid;
   logic [N-1:0][W-1:0] req_data;
   logic [N-1:0]      req_ready;
   logic              dp_valid;
   logic [W-1:0]      dp_data;
   logic [W-1:0]      dp_result;
   logic [N-1:0]      rsp_valid;
   logic [W-1:0]      rsp_data;
   logic              drain_req;
   logic              drain_ack;
   logic              busy;
`ifdef SVNET_PIPE_ARB_LOCK_EN
   logic [N-1:0]      req_lock;
`endif

   int n_vec = 0;
   int n_err = 0;

   int t3_id  [5] = '{1, 3, 1, 3, 1};
   int t3_dat [5] = '{16'h102, 16'h104, 16'h102, 16'h104, 16'h102};

   always #5 clk = ~clk;

   svnet_pipe_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef SVNET_PIPE_ARB_LOCK_EN
      .req_lock  (req_lock),
`endif
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .dp_valid  (dp_valid),
      .dp_data   (dp_data),
      .dp_result (dp_result),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .drain_req (drain_req),
      .drain_ack (drain_ack),
      .busy      (busy)
   );

   // Datapath model: not reset, so it keeps returning results across a reset.
   logic [W-1:0] dpm0, dpm1, dpm2;
   always @(posedge clk) begin
      dpm0 <= dp_data + 16'd1;
      dpm1 <= dpm0;
      dpm2 <= dpm1;
   end
   assign dp_result = dpm2;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] oh(input int i);
      return 32'd1 << i;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      drain_req = 1'b0;
      req_valid = 4'hF;
      for (int i = 0; i < N; i++) req_data[i] = 16'h100 + 16'(i);
`ifdef SVNET_PIPE_ARB_LOCK_EN
      req_lock  = '0;
`endif

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_dpv",   32'(dp_valid),  0);
      chk("rst_dpd",   32'(dp_data),   0);
      chk("rst_rspv",  32'(rsp_valid), 0);
      chk("rst_rspd",  32'(rsp_data),  0);
      chk("rst_ack",   32'(drain_ack), 0);
      chk("rst_busy",  32'(busy),      0);

      // Test 1: all valid, round-robin 0,1,2,3,0, responses 5 cycles later
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t1_first_cycle_ready", 32'(req_ready), 0);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         if (c == 5) req_valid = 4'h0;
         @(negedge clk);
         chk("t1_gnt",  32'(req_ready), (c < 5) ? oh(c % 4) : 0);
         chk("t1_dpv",  32'(dp_valid),  (c >= 1 && c <= 5) ? 1 : 0);
         if (c >= 1 && c <= 5) chk("t1_dpd", 32'(dp_data), 32'h100 + 32'((c - 1) % 4));
         chk("t1_rspv", 32'(rsp_valid), (c >= 5) ? oh((c - 5) % 4) : 0);
         if (c >= 5) chk("t1_rspd", 32'(rsp_data), 32'h101 + 32'((c - 5) % 4));
      end

      // Test 2: sole requester 2, six back-to-back grants
      for (int c = 0; c < 11; c++) begin
         @(posedge clk); #1;
         if (c < 6) begin
            req_valid   = 4'b0100;
            req_data[2] = 16'h10 + 16'(c);
         end else begin
            req_valid = 4'h0;
         end
         @(negedge clk);
         chk("t2_gnt",  32'(req_ready), (c < 6) ? 32'b0100 : 0);
         chk("t2_rspv", 32'(rsp_valid), (c >= 5) ? 32'b0100 : 0);
         if (c >= 5) chk("t2_rspd", 32'(rsp_data), 32'h11 + 32'(c - 5));
      end

      // Test 3: pointer moved to 2, then requesters 1 and 3 alternate
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (c == 0)     req_valid = 4'b0010;
         else if (c < 5) req_valid = 4'b1010;
         else            req_valid = 4'h0;
         @(negedge clk);
         if (c < 5) chk("t3_gnt", 32'(req_ready), oh(t3_id[c]));
         chk("t3_gnt0", 32'(req_ready[0]), 0);
         if (c >= 5 && c < 10) begin
            chk("t3_rspv", 32'(rsp_valid), oh(t3_id[c - 5]));
            chk("t3_rspd", 32'(rsp_data),  32'(t3_dat[c - 5]));
         end
         if (c == 11) chk("t3_idle", 32'(busy), 0);
      end

      // Test 4: drain with three operations in flight (grants 2,3,0)
      for (int c = 0; c < 13; c++) begin
         @(posedge clk); #1;
         req_valid = 4'hF;
         drain_req = (c >= 3 && c <= 9);
         @(negedge clk);
         chk("t4_gnt", 32'(req_ready),
             (c == 0) ? 32'b0100 : (c == 1) ? 32'b1000 : (c == 2) ? 32'b0001 :
             (c == 11) ? 32'b0010 : (c == 12) ? 32'b0100 : 0);
         chk("t4_busy", 32'(busy), ((c >= 1 && c <= 7) || c == 12) ? 1 : 0);
         chk("t4_ack",  32'(drain_ack), (c == 9) ? 1 : 0);
         chk("t4_rspv", 32'(rsp_valid),
             (c == 5) ? 32'b0100 : (c == 6) ? 32'b1000 : (c == 7) ? 32'b0001 : 0);
         if (c == 5) chk("t4_rspd2", 32'(rsp_data), 32'h16);
         if (c == 6) chk("t4_rspd3", 32'(rsp_data), 32'h104);
         if (c == 7) chk("t4_rspd0", 32'(rsp_data), 32'h101);
      end

      // Test 5: asynchronous reset with two operations in flight
      @(posedge clk); #1;
      chk("t5_pre_dpv",   32'(dp_valid),  1);
      chk("t5_pre_busy",  32'(busy),      1);
      chk("t5_pre_ready", 32'(req_ready), 32'b1000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_ready", 32'(req_ready), 0);
      chk("t5_dpv",   32'(dp_valid),  0);
      chk("t5_dpd",   32'(dp_data),   0);
      chk("t5_rspd",  32'(rsp_data),  0);
      chk("t5_busy",  32'(busy),      0);
      @(negedge clk);
      req_valid = 4'h0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk);
         @(negedge clk);
         chk("t5_post_rspv", 32'(rsp_valid), 0);
         chk("t5_post_busy", 32'(busy),      0);
         chk("t5_post_dpv",  32'(dp_valid),  0);
      end

`ifdef SVNET_PIPE_ARB_LOCK_EN
      // Lock: requester 0 holds the grant for four cycles, then 1 wins
      req_valid = 4'b0011;
      req_lock  = 4'b0001;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         if (c == 4) req_lock = 4'b0000;
         @(negedge clk);
         chk("lock_gnt", 32'(req_ready), (c < 4) ? 32'b0001 : 32'b0010);
      end
      req_valid = 4'h0;
`endif

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
